seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 42 ++++
 rtl/seq_alu_if.sv | 30 +++
 rtl/seq_alu_muldiv.sv | 162 ++++++++++++++++
 rtl/seq_alu.sv | 164 ++++++++++++++++
 tb/tb_seq_alu.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op-code map, FSM state encoding and the divide-by-zero
// quotient constant shared by the sequential ALU and its test bench.
package seq_alu_pkg;

  // Classic ALU ops (codes 10 and 11 are reserved)
  localparam logic [4:0] OP_ADDU  = 5'd0;
  localparam logic [4:0] OP_SUBU  = 5'd1;
  localparam logic [4:0] OP_SLT   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_NOR   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_SLLV  = 5'd12;
  localparam logic [4:0] OP_SRA   = 5'd13;
  localparam logic [4:0] OP_SRAV  = 5'd14;
  localparam logic [4:0] OP_SRLV  = 5'd15;
  localparam logic [4:0] OP_LUI   = 5'd16;

  // Extended ops
  localparam logic [4:0] OP_ADD   = 5'd17;
  localparam logic [4:0] OP_SUB   = 5'd18;
  localparam logic [4:0] OP_MULT  = 5'd19;
  localparam logic [4:0] OP_MULTU = 5'd20;
  localparam logic [4:0] OP_DIV   = 5'd21;
  localparam logic [4:0] OP_DIVU  = 5'd22;
  localparam logic [4:0] OP_MFHI  = 5'd23;
  localparam logic [4:0] OP_MFLO  = 5'd24;

  // Quotient reported on divide by zero; sliced to the datapath width
  localparam logic [63:0] DIV0_QUO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle of the sequential ALU.
// master = requester side, slave = the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) ();
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, op, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow, hi, lo
  );

  modport slave (
    input  in_valid, op, a, b, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow, hi, lo
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative magnitude multiplier (shift-add) and, when
// SEQ_ALU_DIV_EN is defined, restoring divider. Operands are captured on
// start; the loop then runs exactly WIDTH cycles. done is asserted during
// the last iteration and res_hi/res_lo carry the sign-corrected result in
// that same cycle so the caller can register it on the final edge.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);

  logic               busy_q, busy_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   shr_q, shr_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc, mul_shr;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // shift-add step: acc:shr shifts right, multiplicand added when shr[0]
  assign mul_sum = {1'b0, acc_q} + (shr_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_acc = mul_sum[WIDTH:1];
  assign mul_shr = {mul_sum[0], shr_q[WIDTH-1:1]};
  assign prod    = {mul_acc, mul_shr};
  assign prod_s  = neg_q ? -prod : prod;

`ifdef SEQ_ALU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] a_org_q, a_org_d;
  logic [WIDTH:0]   div_sh, div_tr;
  logic             div_ok;
  logic [WIDTH-1:0] div_acc, div_shr;

  // restoring step: remainder:quotient shifts left, subtract if it fits
  assign div_sh  = {acc_q, shr_q[WIDTH-1]};
  assign div_tr  = div_sh - {1'b0, mcand_q};
  assign div_ok  = ~div_tr[WIDTH];
  assign div_acc = div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_shr = {shr_q[WIDTH-2:0], div_ok};
`endif

  assign done = busy_q && (cnt_q == CNT_ONE);

  // operand capture on start, one iteration per cycle while busy
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shr_d   = shr_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
`ifdef SEQ_ALU_DIV_EN
    is_div_d = is_div_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    a_org_d  = a_org_q;
`endif
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = CNT_LOAD;
      acc_d   = '0;
      shr_d   = a_mag;
      mcand_d = b_mag;
      neg_d   = a_neg ^ b_neg;
`ifdef SEQ_ALU_DIV_EN
      is_div_d = is_div;
      rneg_d   = a_neg;
      div0_d   = (b == '0);
      a_org_d  = a;
`endif
    end else if (busy_q) begin
      cnt_d  = cnt_q - CNT_ONE;
      busy_d = (cnt_q != CNT_ONE);
      acc_d  = mul_acc;
      shr_d  = mul_shr;
`ifdef SEQ_ALU_DIV_EN
      if (is_div_q) begin
        acc_d = div_acc;
        shr_d = div_shr;
      end
`endif
    end
  end

  // final sign fix-up and divide special cases
  always_comb begin
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
`ifdef SEQ_ALU_DIV_EN
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = a_org_q;
        res_lo = DIV0_QUO[WIDTH-1:0];
      end else begin
        res_lo = neg_q  ? -div_shr : div_shr;
        res_hi = rneg_q ? -div_acc : div_acc;
      end
    end
`endif
  end

  // datapath and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      shr_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      a_org_q  <= '0;
`endif
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shr_q   <= shr_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
`ifdef SEQ_ALU_DIV_EN
      is_div_q <= is_div_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      a_org_q  <= a_org_d;
`endif
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready request and response.
// Single-cycle ops are evaluated here; mult/multu (and div/divu when
// SEQ_ALU_DIV_EN is defined) run WIDTH cycles in seq_alu_muldiv.
// Without SEQ_ALU_DIV_EN, div/divu complete like undefined ops.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// MUL   | iterative multiply in progress
// DIV   | iterative divide in progress
// DONE  | out_valid=1, outputs held until out_ready
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic             is_mul, md_sgn, md_start, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign sum    = bus.a + bus.b;
  assign diff   = bus.a - bus.b;
  assign is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign md_sgn = (bus.op == OP_MULT) || (bus.op == OP_DIV);

`ifdef SEQ_ALU_DIV_EN
  logic is_div;
  assign is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
`endif

  seq_alu_muldiv #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
`ifdef SEQ_ALU_DIV_EN
    .is_div (is_div),
`endif
    .sgn    (md_sgn),
    .a      (bus.a),
    .b      (bus.b),
    .done   (md_done),
    .res_hi (md_hi),
    .res_lo (md_lo)
  );

  // single-cycle result and signed overflow from the live request
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADDU: alu_res = sum;
      OP_SUBU: alu_res = diff;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_AND:  alu_res = bus.a & bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLL:  alu_res = bus.b << bus.shamt;
      OP_SRL:  alu_res = bus.b >> bus.shamt;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLLV: alu_res = bus.b << bus.a[SHW-1:0];
      OP_SRA:  alu_res = $signed(bus.b) >>> bus.shamt;
      OP_SRAV: alu_res = $signed(bus.b) >>> bus.a[SHW-1:0];
      OP_SRLV: alu_res = bus.b >> bus.a[SHW-1:0];
      OP_LUI:  alu_res = bus.b << (WIDTH/2);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // next state, muldiv start and output register updates
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    md_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_mul) begin
            md_start = 1'b1;
            state_d  = MUL;
          end
`ifdef SEQ_ALU_DIV_EN
          else if (is_div) begin
            md_start = 1'b1;
            state_d  = DIV;
          end
`endif
          else begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
            state_d  = DONE;
          end
        end
      end
      MUL, DIV: begin
        if (md_done) begin
          hi_d     = md_hi;
          lo_d     = md_lo;
          result_d = md_lo;
          ovf_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = rst | (result_q == '0);
  assign bus.overflow  = ovf_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu (WIDTH=32) with a scoreboard
// queue filled at acceptance and drained by an output monitor.
module tb_seq_alu;
  import seq_alu_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        ovf;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    bit          cr;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus_if ();
  seq_alu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   next_id = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_v = 1'b0;
  int   valid_cyc = 0;
  logic [31:0] hv, lv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus_if.out_valid && !prev_v) valid_cyc = cyc;
      prev_v = bus_if.out_valid;
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'(bus_if.out_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.cr) begin
            chk($sformatf("v%0d.result", mon_e.id), 64'(bus_if.result), 64'(mon_e.res));
            chk($sformatf("v%0d.zero", mon_e.id), 64'(bus_if.zero), 64'(mon_e.res == 32'd0));
          end
          chk($sformatf("v%0d.overflow", mon_e.id), 64'(bus_if.overflow), 64'(mon_e.ovf));
          chk($sformatf("v%0d.hi", mon_e.id), 64'(bus_if.hi), 64'(mon_e.hi));
          chk($sformatf("v%0d.lo", mon_e.id), 64'(bus_if.lo), 64'(mon_e.lo));
          chk($sformatf("v%0d.latency", mon_e.id), 64'(valid_cyc - mon_e.acc_cyc), 64'(mon_e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] er, input logic eo,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input bit cr, input bit push);
    int   t = 0;
    exp_t e;
    @(negedge clk);
    while (!bus_if.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus_if.in_ready) begin
      chk("issue_timeout", 64'(bus_if.in_ready), 64'd1);
      return;
    end
    bus_if.op       = op;
    bus_if.a        = a;
    bus_if.b        = b;
    bus_if.shamt    = sh;
    bus_if.in_valid = 1'b1;
    if (push) begin
      e.id = next_id; e.res = er; e.ovf = eo; e.hi = eh; e.lo = el;
      e.lat = lat; e.cr = cr; e.acc_cyc = cyc;
      sb.push_back(e);
    end
    next_id++;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.op       = 5'($urandom());
    bus_if.a        = $urandom();
    bus_if.b        = $urandom();
    bus_if.shamt    = 5'($urandom());
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int seen;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    bus_if.op        = 5'd0;
    bus_if.a         = 32'd0;
    bus_if.b         = 32'd0;
    bus_if.shamt     = 5'd0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.zero",      64'(bus_if.zero),      64'd1);
    chk("rst.in_ready",  64'(bus_if.in_ready),  64'd1);
    chk("rst.out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst.result",    64'(bus_if.result),    64'd0);
    chk("rst.overflow",  64'(bus_if.overflow),  64'd0);
    chk("rst.hi",        64'(bus_if.hi),        64'd0);
    chk("rst.lo",        64'(bus_if.lo),        64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // op, a, b, shamt, result, ovf, hi, lo, latency, check result, push
    issue(OP_ADD,  32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_ADDU, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_SUB,  32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_SUBU, 32'h5, 32'h5, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_SLT,  32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_SLTU, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_OR,   32'hF0F0F0F0, 32'h0F0F0000, 5'd0, 32'hFFFFF0F0, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 5'd0, 32'hF0F00F0F, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_NOR,  32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_SLL,  32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_SRL,  32'h0, 32'h80000000, 5'd31, 32'h1, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_SLLV, 32'd36, 32'h1, 5'd0, 32'h10, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_SRLV, 32'd4, 32'h80000000, 5'd0, 32'h08000000, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_SRAV, 32'd8, 32'h80000000, 5'd0, 32'hFF800000, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_LUI,  32'h0, 32'h1234ABCD, 5'd0, 32'hABCD0000, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);

    issue(OP_MULT,  32'hFFFFFFFF, 32'h2, 5'd0, 32'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0, 1'b1);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h2, 5'd0, 32'h0, 1'b0, 32'h1, 32'hFFFFFFFE, 33, 1'b0, 1'b1);
    issue(OP_MFHI,  32'h0, 32'h0, 5'd0, 32'h1, 1'b0, 32'h1, 32'hFFFFFFFE, 1, 1'b1, 1'b1);
    issue(OP_MFLO,  32'h0, 32'h0, 5'd0, 32'hFFFFFFFE, 1'b0, 32'h1, 32'hFFFFFFFE, 1, 1'b1, 1'b1);
    issue(5'd10,    32'h5, 32'h6, 5'd0, 32'h0, 1'b0, 32'h1, 32'hFFFFFFFE, 1, 1'b1, 1'b1);
    issue(5'd31,    32'h5, 32'h6, 5'd0, 32'h0, 1'b0, 32'h1, 32'hFFFFFFFE, 1, 1'b1, 1'b1);

`ifdef SEQ_ALU_DIV_EN
    issue(OP_DIV,  32'hFFFFFFF9, 32'h2, 5'd0, 32'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, 1'b1);
    issue(OP_DIV,  32'h5, 32'h0, 5'd0, 32'h0, 1'b0, 32'h5, 32'hFFFFFFFF, 33, 1'b0, 1'b1);
    issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0, 32'h0, 32'h80000000, 33, 1'b0, 1'b1);
    issue(OP_DIVU, 32'h9, 32'h3, 5'd0, 32'h0, 1'b0, 32'h0, 32'h3, 33, 1'b0, 1'b1);
    hv = 32'h0;
    lv = 32'h3;
`else
    issue(OP_DIVU, 32'h9, 32'h3, 5'd0, 32'h0, 1'b0, 32'h1, 32'hFFFFFFFE, 1, 1'b1, 1'b1);
    issue(OP_DIV,  32'h7, 32'h2, 5'd0, 32'h0, 1'b0, 32'h1, 32'hFFFFFFFE, 1, 1'b1, 1'b1);
    hv = 32'h1;
    lv = 32'hFFFFFFFE;
`endif

    // back-pressure: result held, no new request taken while DONE
    wait_drain();
    bus_if.out_ready = 1'b0;
    issue(OP_SRA, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, hv, lv, 1, 1'b1, 1'b1);
    t = 0;
    @(negedge clk);
    while (!bus_if.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d.result", i),    64'(bus_if.result),    64'hF8000000);
      chk($sformatf("hold%0d.in_ready", i),  64'(bus_if.in_ready),  64'd0);
      chk($sformatf("hold%0d.out_valid", i), 64'(bus_if.out_valid), 64'd1);
      bus_if.op       = OP_ADDU;
      bus_if.a        = 32'h1;
      bus_if.b        = 32'h1;
      bus_if.in_valid = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold.after_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("hold.after_in_ready",  64'(bus_if.in_ready),  64'd1);
    wait_drain();

    // reset in the middle of a multiply abandons it
    issue(OP_MULT, 32'h3, 32'h4, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 33, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst.in_ready",  64'(bus_if.in_ready),  64'd1);
    chk("midrst.out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("midrst.hi",        64'(bus_if.hi),        64'd0);
    chk("midrst.lo",        64'(bus_if.lo),        64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.out_valid) seen++;
      @(negedge clk);
    end
    chk("midrst.no_out_valid", 64'(seen), 64'd0);
    issue(OP_MFLO, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);
    issue(OP_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1);

    wait_drain();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
